// File: rtl/std_cache_pkg.sv
// ============================================================================
// std_cache_pkg : shared bypass request/response types and responder FSM states
// Revision      : 1.0
// ============================================================================
`default_nettype none

package std_cache_pkg;

  localparam int BYPASS_ID_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } bypass_state_e;

  typedef struct packed {
    logic                   req;
    logic [1:0]             reqtype;
    logic [3:0]             amo;
    logic [BYPASS_ID_W-1:0] id;
    logic [63:0]            addr;
    logic [63:0]            wdata;
    logic                   we;
    logic [7:0]             be;
    logic [1:0]             size;
  } bypass_req_t;

  typedef struct packed {
    logic        gnt;
    logic        valid;
    logic [63:0] rdata;
  } bypass_rsp_t;

endpackage

`default_nettype wire

// File: rtl/std_bypass_responder.sv
// ============================================================================
// std_bypass_responder : single-outstanding bypass responder with watchdog
// Revision             : 1.0
// ============================================================================
`default_nettype none

module std_bypass_responder
  import std_cache_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned TimeoutW      = $clog2(TimeoutCycles + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  bypass_req_t            bypass_req_i,
  output bypass_rsp_t            bypass_rsp_o,
  output logic                   bypass_err_o,
  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  output bypass_req_t            mem_req_o,
  input  logic                   mem_rsp_valid_i,
  input  logic [BYPASS_ID_W-1:0] mem_rsp_id_i,
  input  logic [63:0]            mem_rsp_rdata_i,
  input  logic                   mem_rsp_err_i,
  output logic                   busy_o,
  output logic                   id_mismatch_o
);

  // A disabled watchdog still needs a legal one-bit counter.
  localparam int unsigned CNT_W    = (TimeoutW < 1) ? 1 : TimeoutW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TimeoutCycles - 1);
  localparam bit WDOG_EN = (TimeoutCycles != 0);

  bypass_state_e     state_q, state_d;
  bypass_req_t       req_q, req_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              id_mismatch_q, id_mismatch_d;

  logic gnt, rsp_valid, req_valid, rsp_hit, timeout;

  assign rsp_hit = mem_rsp_valid_i && (mem_rsp_id_i == req_q.id);
  assign timeout = WDOG_EN && (cnt_q == CNT_LAST);

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    cnt_d         = cnt_q;
    id_mismatch_d = id_mismatch_q;
    gnt           = 1'b0;
    rsp_valid     = 1'b0;
    req_valid     = 1'b0;

    case (state_q)
      IDLE: begin
        gnt = bypass_req_i.req && !rst_i;
        if (bypass_req_i.req) begin
          req_d     = bypass_req_i;
          req_d.req = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        req_valid = 1'b1;
        if (mem_req_ready_i) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_rsp_valid_i && !rsp_hit) begin
          id_mismatch_d = 1'b1;
        end
        // A matching response beats a watchdog expiry in the same cycle.
        if (rsp_hit) begin
          rdata_d = mem_rsp_rdata_i;
          err_d   = mem_rsp_err_i;
          state_d = RESP;
        end else if (timeout) begin
          rdata_d = '1;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (WDOG_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      req_q         <= '0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      cnt_q         <= '0;
      id_mismatch_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
      cnt_q         <= cnt_d;
      id_mismatch_q <= id_mismatch_d;
    end
  end

  assign bypass_rsp_o.gnt   = gnt;
  assign bypass_rsp_o.valid = rsp_valid;
  assign bypass_rsp_o.rdata = rsp_valid ? rdata_q : 64'd0;
  assign bypass_err_o       = rsp_valid & err_q;
  assign mem_req_valid_o    = req_valid;
  assign mem_req_o          = req_q;
  assign busy_o             = (state_q != IDLE);
  assign id_mismatch_o      = id_mismatch_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == ISSUE) begin
      assert (!mem_rsp_valid_i)
        else $error("backend response arrived before request handshake");
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_std_bypass_responder.sv
// ============================================================================
// tb_std_bypass_responder : directed self-checking bench for the bypass responder
// Revision                : 1.0
// ============================================================================
`default_nettype none

module tb_std_bypass_responder;
  import std_cache_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  bypass_req_t      req;
  bypass_rsp_t      rsp;
  logic             err;
  logic             mreq_valid;
  logic             mreq_ready;
  bypass_req_t      mreq;
  logic             mrsp_valid;
  logic [3:0]       mrsp_id;
  logic [63:0]      mrsp_rdata;
  logic             mrsp_err;
  logic             busy;
  logic             idmm;

  int errors = 0;
  int checks = 0;
  bypass_req_t exp_req;

  always #5 clk = ~clk;

  std_bypass_responder #(.TimeoutCycles(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .bypass_req_i   (req),
    .bypass_rsp_o   (rsp),
    .bypass_err_o   (err),
    .mem_req_valid_o(mreq_valid),
    .mem_req_ready_i(mreq_ready),
    .mem_req_o      (mreq),
    .mem_rsp_valid_i(mrsp_valid),
    .mem_rsp_id_i   (mrsp_id),
    .mem_rsp_rdata_i(mrsp_rdata),
    .mem_rsp_err_i  (mrsp_err),
    .busy_o         (busy),
    .id_mismatch_o  (idmm)
  );

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_req(input logic [3:0] id, input logic [63:0] addr);
    req         = '0;
    req.req     = 1'b1;
    req.id      = id;
    req.addr    = addr;
    req.size    = 2'd3;
  endtask

  task automatic backend(input logic [3:0] id, input logic [63:0] d, input logic e);
    mrsp_valid = 1'b1;
    mrsp_id    = id;
    mrsp_rdata = d;
    mrsp_err   = e;
  endtask

  task automatic no_backend();
    mrsp_valid = 1'b0;
    mrsp_id    = 4'd0;
    mrsp_rdata = 64'd0;
    mrsp_err   = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    req        = '0;
    mreq_ready = 1'b1;
    no_backend();

    // Reset state
    cyc(); cyc();
    chk("rst_valid", rsp.valid, 1'b0);
    chk("rst_gnt", rsp.gnt, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mreq_valid", mreq_valid, 1'b0);
    rst = 1'b0;
    cyc();
    chk("rst_rdata", rsp.rdata, 64'd0);
    chk("rst_idmm", idmm, 1'b0);

    // Read with 1-cycle-late backend
    rd_req(4'd5, 64'h8000_0010);
    #1;
    chk("t1_gnt", rsp.gnt, 1'b1);
    cyc();
    req = '0;
    #1;
    chk("t1_mreq_valid", mreq_valid, 1'b1);
    chk("t1_mreq_addr", mreq.addr, 64'h8000_0010);
    chk("t1_mreq_id", mreq.id, 4'd5);
    chk("t1_busy", busy, 1'b1);
    cyc();
    chk("t1_mreq_drop", mreq_valid, 1'b0);
    cyc();
    backend(4'd5, 64'hDEAD_BEEF_0123_4567, 1'b0);
    cyc();
    no_backend();
    chk("t1_valid", rsp.valid, 1'b1);
    chk("t1_rdata", rsp.rdata, 64'hDEAD_BEEF_0123_4567);
    chk("t1_err", err, 1'b0);
    cyc();
    chk("t1_valid_once", rsp.valid, 1'b0);
    chk("t1_rdata_zero", rsp.rdata, 64'd0);
    chk("t1_idle", busy, 1'b0);

    // Write with 7 cycles of backpressure; requester keeps req high
    mreq_ready = 1'b0;
    req        = '0;
    req.req    = 1'b1;
    req.id     = 4'd2;
    req.addr   = 64'h8000_0100;
    req.wdata  = 64'hA5A5_A5A5_A5A5_A5A5;
    req.we     = 1'b1;
    req.be     = 8'h0F;
    req.size   = 2'd3;
    req.amo    = 4'h6;
    exp_req    = req;
    #1;
    chk("t2_gnt", rsp.gnt, 1'b1);
    cyc();
    req.addr  = 64'h1234_0000;
    req.wdata = 64'd0;
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("t2_stall_valid", mreq_valid, 1'b1);
      chk("t2_stall_req", mreq, exp_req);
      chk("t2_no_gnt", rsp.gnt, 1'b0);
      cyc();
    end
    mreq_ready = 1'b1;
    #1;
    chk("t2_hs_valid", mreq_valid, 1'b1);
    cyc();
    req = '0;
    chk("t2_wait_busy", busy, 1'b1);
    backend(4'd2, 64'd0, 1'b0);
    cyc();
    no_backend();
    chk("t2_valid", rsp.valid, 1'b1);
    chk("t2_err", err, 1'b0);
    cyc();
    chk("t2_valid_once", rsp.valid, 1'b0);

    // Wrong id dropped, then matching id with backend error
    rd_req(4'd5, 64'h8000_0200);
    cyc();
    req = '0;
    cyc();
    backend(4'd3, 64'h1111, 1'b0);
    cyc();
    no_backend();
    chk("t4_drop_valid", rsp.valid, 1'b0);
    chk("t4_idmm", idmm, 1'b1);
    chk("t4_busy", busy, 1'b1);
    backend(4'd5, 64'h2222, 1'b1);
    cyc();
    no_backend();
    chk("t4_valid", rsp.valid, 1'b1);
    chk("t4_rdata", rsp.rdata, 64'h2222);
    chk("t4_err", err, 1'b1);
    chk("t4_idmm_sticky", idmm, 1'b1);
    cyc();

    // Timeout: handshake cycle H, WAIT H+1..H+16, RESP at H+17
    rd_req(4'd7, 64'h8000_0300);
    cyc();
    req = '0;
    cyc();
    for (int k = 1; k <= 16; k++) begin
      chk("t3_no_valid", rsp.valid, 1'b0);
      cyc();
    end
    chk("t3_valid", rsp.valid, 1'b1);
    chk("t3_rdata", rsp.rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t3_err", err, 1'b1);
    cyc();
    chk("t3_after_valid", rsp.valid, 1'b0);
    chk("t3_after_err", err, 1'b0);

    // Response lands in the last WAIT cycle, together with expiry
    rd_req(4'd9, 64'h8000_0400);
    cyc();
    req = '0;
    cyc();
    repeat (15) cyc();
    chk("t6_still_wait", busy, 1'b1);
    backend(4'd9, 64'h0BAD_F00D, 1'b0);
    cyc();
    no_backend();
    chk("t6_valid", rsp.valid, 1'b1);
    chk("t6_rdata", rsp.rdata, 64'h0BAD_F00D);
    chk("t6_err", err, 1'b0);
    cyc();

    // Reset during WAIT, then a late backend response
    rd_req(4'd4, 64'h8000_0500);
    cyc();
    req = '0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t5_busy", busy, 1'b0);
    chk("t5_idmm_clr", idmm, 1'b0);
    backend(4'd4, 64'h5555, 1'b0);
    cyc();
    no_backend();
    chk("t5_late_valid", rsp.valid, 1'b0);
    chk("t5_late_busy", busy, 1'b0);
    cyc();
    chk("t5_late_valid2", rsp.valid, 1'b0);
    rd_req(4'd6, 64'h8000_0600);
    #1;
    chk("t5_gnt", rsp.gnt, 1'b1);
    cyc();
    req = '0;
    chk("t5_mreq_id", mreq.id, 4'd6);
    cyc();
    backend(4'd6, 64'h6666, 1'b0);
    cyc();
    no_backend();
    chk("t5_valid", rsp.valid, 1'b1);
    chk("t5_rdata", rsp.rdata, 64'h6666);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule

`default_nettype wire
